// File: rtl/sync_up_counter_mod_pkg.sv
// Shared counter definitions: per-edge decoded operation and a compile-time log2 helper.
package counter_pkg;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_LOAD,
        CNT_INC,
        CNT_WRAP
    } cnt_op_t;

    // Smallest r with 2**r >= n; evaluated at elaboration time only.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_up_counter_mod_if.sv
// Control/status bundle of the modulo-N up counter; master drives controls, slave is the counter.
interface sync_up_counter_mod_if #(
    parameter int WIDTH = 5
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_ovf;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             div_out;
    logic             ovf;

    modport master (
        output en, load, load_val, clr_ovf,
        input  q, tc, div_out, ovf
    );

    modport slave (
        input  en, load, load_val, clr_ovf,
        output q, tc, div_out, ovf
    );
endinterface

// File: rtl/sync_up_counter_mod_div_out_gen.sv
// Registered divided-frequency output: high while the next count sits in the upper part of the sequence.
module div_out_gen #(
    parameter int WIDTH   = 5,
    parameter int MODULUS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] q_next,
    output logic             div_out
);

    localparam logic [WIDTH-1:0] HALF = WIDTH'(MODULUS / 2);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_out <= 1'b0;
        end else if (en) begin
            div_out <= (q_next >= HALF);
        end
    end

endmodule

// File: rtl/sync_up_counter_mod.sv
// Synchronous modulo-N up counter with enable, clamped parallel load, tc pulse and divided output.
// Optional sticky wrap flag enabled by defining SYNC_UP_COUNTER_OVF_STICKY_EN.
module sync_up_counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH   = 5,
    parameter int MODULUS = 32
) (
    input logic                 clk,
    input logic                 reset,
    sync_up_counter_mod_if.slave bus
);

    generate
        if (MODULUS < 2 || clog2(MODULUS) > WIDTH) begin : g_bad_modulus
            $error("sync_up_counter_mod: MODULUS out of range for WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);

    cnt_op_t          op;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next;
    logic             tc_r;
    logic             div_r;

    always_comb begin
        op = CNT_HOLD;
        if (bus.load) begin
            op = CNT_LOAD;
        end else if (bus.en) begin
            op = (q_r == MAX_Q) ? CNT_WRAP : CNT_INC;
        end
    end

    always_comb begin
        q_next = q_r;
        case (op)
            CNT_LOAD: q_next = ({1'b0, bus.load_val} >= MOD_W) ? MAX_Q : bus.load_val;
            CNT_INC:  q_next = q_r + 1'b1;
            CNT_WRAP: q_next = '0;
            default:  q_next = q_r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_r  <= '0;
            tc_r <= 1'b0;
        end else begin
            q_r  <= q_next;
            tc_r <= (op == CNT_WRAP);
        end
    end

    // A load also moves q, so div_out follows it to stay consistent with the count.
    div_out_gen #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_div_out_gen (
        .clk     (clk),
        .reset   (reset),
        .en      (bus.en | bus.load),
        .q_next  (q_next),
        .div_out (div_r)
    );

`ifdef SYNC_UP_COUNTER_OVF_STICKY_EN
    logic ovf_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_r <= 1'b0;
        end else if (op == CNT_WRAP) begin
            ovf_r <= 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_r <= 1'b0;
        end
    end

    assign bus.ovf = ovf_r;
`else
    logic unused_clr_ovf;
    assign unused_clr_ovf = bus.clr_ovf;
    assign bus.ovf        = 1'b0;
`endif

    assign bus.q       = q_r;
    assign bus.tc      = tc_r;
    assign bus.div_out = div_r;

endmodule
